// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier.
// One-hot state encoding, control bundle and add/sub selector.
package booth_pkg;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    LOAD  = 5'b00010,
    EVAL  = 5'b00100,
    SHIFT = 5'b01000,
    DONE  = 5'b10000
  } booth_state_e;

  typedef struct packed {
    logic load;
    logic add_en;
    logic add_sub;
    logic shift;
  } control_t;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Booth pairs 00/11 leave the accumulator untouched
  function automatic logic is_skip_pair(
    input logic [1:0] pair
  );
    return (pair == 2'b00) || (pair == 2'b11);
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational accumulator update: a + b or a - b.
// Width includes one guard bit so the most negative operand fits.
module booth_addsub
  import booth_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         add_sub,
  output logic [W-1:0] sum
);

  always_comb begin
    sum = a + b;
    if (add_sub == SUB)
      sum = a - b;
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH.
// Define BOOTH_ZERO_SKIP_EN to shift directly from EVAL on 00/11 pairs.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 step,
  output logic [CNT_W-1:0]     iter,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  booth_state_e state;
  booth_state_e state_nx;
  control_t     ctrl;

  logic [WIDTH:0]     hq;
  logic [WIDTH-1:0]   lq;
  logic               q_1;
  logic [WIDTH:0]     m;
  logic [WIDTH:0]     sum;
  logic [1:0]         pair;
  logic               last;
  logic [2*WIDTH+1:0] shr;

  assign pair = {lq[0], q_1};
  assign last = (iter == CNT_W'(1));

  // {HQ,LQ,Q_1} after one arithmetic right shift
  assign shr = {hq[WIDTH], hq, lq};

  booth_addsub #(
    .W (WIDTH + 1)
  ) u_addsub (
    .a       (hq),
    .b       (m),
    .add_sub (ctrl.add_sub),
    .sum     (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (init) state_nx = LOAD;
      LOAD:  state_nx = EVAL;
      EVAL: begin
`ifdef BOOTH_ZERO_SKIP_EN
        if (is_skip_pair(pair))
          state_nx = last ? DONE : EVAL;
        else
          state_nx = SHIFT;
`else
        state_nx = SHIFT;
`endif
      end
      SHIFT: state_nx = last ? DONE : EVAL;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ctrl = '0;
    busy = (state != IDLE);
    done = (state == DONE);
    unique case (state)
      LOAD: ctrl.load = 1'b1;
      EVAL: begin
        ctrl.add_en  = !is_skip_pair(pair);
        ctrl.add_sub = (pair == 2'b10) ? SUB : ADD;
`ifdef BOOTH_ZERO_SKIP_EN
        ctrl.shift   = is_skip_pair(pair);
`endif
      end
      SHIFT: ctrl.shift = 1'b1;
      default: ;
    endcase
    step = ctrl.shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hq      <= '0;
      lq      <= '0;
      q_1     <= 1'b0;
      m       <= '0;
      iter    <= '0;
      product <= '0;
    end else if (ctrl.load) begin
      m    <= {multiplicand[WIDTH-1], multiplicand};
      lq   <= multiplier;
      hq   <= '0;
      q_1  <= 1'b0;
      iter <= CNT_W'(WIDTH);
    end else if (ctrl.add_en) begin
      hq <= sum;
    end else if (ctrl.shift) begin
      hq      <= shr[2*WIDTH+1:WIDTH+1];
      lq      <= shr[WIDTH:1];
      q_1     <= shr[0];
      iter    <= iter - CNT_W'(1);
      product <= shr[2*WIDTH:1];
    end
  end

endmodule
